// File: rtl/spi_slave_mem.sv
// SPI slave register memory: oversamples sclk/mosi/cs on pclk and decodes
// LSB-first address + data frames into writes or miso read-back.
`timescale 1ns/1ps
module spi_slave_mem #(
  parameter int WIDTH  = 8,
  parameter int DEPTH  = 128,
  parameter int DEV_ID = 0
) (
  input  logic             i_pclk,
  input  logic             i_prst,
  input  logic             i_sclk,
  input  logic             i_mosi,
  input  logic [3:0]       i_cs,
  output logic             o_miso,
  output logic             o_wr_valid,
  output logic [6:0]       o_wr_addr,
  output logic [WIDTH-1:0] o_wr_data,
  output logic             o_rd_valid,
  output logic             o_busy
);
  localparam int            CW   = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [2:0] {
    S_IDLE = 3'b001,
    S_ADDR = 3'b010,
    S_DATA = 3'b100
  } state_t;

  state_t           r_state, w_state_nxt;
  logic             r_sclk_s1, r_sclk_s2, r_sclk_prev;
  logic             r_mosi_s1, r_mosi_s2;
  logic             r_cs_s1, r_cs_s2;
  logic [CW-1:0]    r_bit_cnt;
  logic [WIDTH-1:0] r_addr_sr, r_data_sr, r_addr, r_rd_sr;
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic             r_miso, r_wr_valid, r_rd_valid;
  logic [6:0]       r_wr_addr;
  logic [WIDTH-1:0] r_wr_data;

  logic             w_cs_sel, w_sclk_fall, w_last;
  logic [CW-1:0]    w_cnt_inc;
  logic [WIDTH-1:0] w_addr_ins, w_data_ins, w_rd_word;

  // Reduction keeps every cs bit in the logic cone; only cs[DEV_ID] matters.
  assign w_cs_sel    = |(i_cs & (4'b0001 << DEV_ID));
  assign w_sclk_fall = r_sclk_prev & ~r_sclk_s2;
  assign w_last      = w_sclk_fall && (r_bit_cnt == LAST);
  assign w_cnt_inc   = r_bit_cnt + CW'(1);
  assign w_rd_word   = r_mem[w_addr_ins[6:0]];

  // Shift registers with the bit arriving this pclk merged in, so the final
  // bit can be used in the same cycle it is sampled.
  always_comb begin
    w_addr_ins            = r_addr_sr;
    w_addr_ins[r_bit_cnt] = r_mosi_s2;
    w_data_ins            = r_data_sr;
    w_data_ins[r_bit_cnt] = r_mosi_s2;
  end

  always_ff @(posedge i_pclk or posedge i_prst) begin
    if (i_prst) begin
      r_sclk_s1   <= 1'b1;
      r_sclk_s2   <= 1'b1;
      r_sclk_prev <= 1'b1;
      r_mosi_s1   <= 1'b1;
      r_mosi_s2   <= 1'b1;
      r_cs_s1     <= 1'b0;
      r_cs_s2     <= 1'b0;
    end else begin
      r_sclk_s1   <= i_sclk;
      r_sclk_s2   <= r_sclk_s1;
      r_sclk_prev <= r_sclk_s2;
      r_mosi_s1   <= i_mosi;
      r_mosi_s2   <= r_mosi_s1;
      r_cs_s1     <= w_cs_sel;
      r_cs_s2     <= r_cs_s1;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (r_cs_s2) w_state_nxt = S_ADDR;
      S_ADDR:  if (!r_cs_s2) w_state_nxt = S_IDLE;
               else if (w_last) w_state_nxt = S_DATA;
      S_DATA:  if (!r_cs_s2) w_state_nxt = S_IDLE;
               else if (w_last) w_state_nxt = S_ADDR;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge i_pclk or posedge i_prst) begin
    if (i_prst) begin
      r_state    <= S_IDLE;
      r_bit_cnt  <= '0;
      r_addr_sr  <= '0;
      r_data_sr  <= '0;
      r_addr     <= '0;
      r_rd_sr    <= '0;
      r_miso     <= 1'b1;
      r_wr_valid <= 1'b0;
      r_rd_valid <= 1'b0;
      r_wr_addr  <= '0;
      r_wr_data  <= '0;
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_wr_valid <= 1'b0;
      r_rd_valid <= 1'b0;
      if (r_state == S_IDLE || !r_cs_s2) begin
        r_bit_cnt <= '0;
        r_miso    <= 1'b1;
      end else if (w_sclk_fall) begin
        r_bit_cnt <= w_cnt_inc;
        if (r_state == S_ADDR) begin
          r_addr_sr <= w_addr_ins;
          if (w_last) begin
            r_addr <= w_addr_ins;
            // Read: first data bit must be on miso before the first data edge.
            if (!w_addr_ins[WIDTH-1]) begin
              r_rd_sr <= w_rd_word;
              r_miso  <= w_rd_word[0];
            end
          end
        end else if (r_addr[WIDTH-1]) begin
          r_data_sr <= w_data_ins;
          if (w_last) begin
            r_mem[r_addr[6:0]] <= w_data_ins;
            r_wr_valid         <= 1'b1;
            r_wr_addr          <= r_addr[6:0];
            r_wr_data          <= w_data_ins;
          end
        end else if (w_last) begin
          r_rd_valid <= 1'b1;
          r_miso     <= 1'b1;
        end else begin
          r_miso <= r_rd_sr[w_cnt_inc];
        end
      end
    end
  end

  assign o_miso     = r_miso;
  assign o_wr_valid = r_wr_valid;
  assign o_wr_addr  = r_wr_addr;
  assign o_wr_data  = r_wr_data;
  assign o_rd_valid = r_rd_valid;
  assign o_busy     = (r_state == S_DATA) || ((r_state == S_ADDR) && (r_bit_cnt != '0));

endmodule

// File: tb/tb_spi_slave_mem.sv
// Directed bench for spi_slave_mem: acts as SPI master with sclk at 1/8 pclk,
// two instances (DEV_ID 0 and 1) share the bus.
`timescale 1ns/1ps
module tb_spi_slave_mem;
  logic       pclk = 1'b0;
  logic       prst = 1'b0;
  logic       sclk = 1'b1;
  logic       mosi = 1'b1;
  logic [3:0] cs   = 4'b0000;

  logic       miso0, wrv0, rdv0, busy0;
  logic [6:0] wra0;
  logic [7:0] wrd0;
  logic       miso1, wrv1, rdv1, busy1;
  logic [6:0] wra1;
  logic [7:0] wrd1;

  int total = 0;
  int bad   = 0;
  int wr_cnt0 = 0, rd_cnt0 = 0, both_cnt = 0;
  int wr_cnt1 = 0, rd_cnt1 = 0, miso1_low = 0, busy1_hi = 0;
  logic mon_en = 1'b0;

  always #5 pclk = ~pclk;

  spi_slave_mem #(.WIDTH(8), .DEPTH(128), .DEV_ID(0)) u_dut0 (
    .i_pclk(pclk), .i_prst(prst), .i_sclk(sclk), .i_mosi(mosi), .i_cs(cs),
    .o_miso(miso0), .o_wr_valid(wrv0), .o_wr_addr(wra0), .o_wr_data(wrd0),
    .o_rd_valid(rdv0), .o_busy(busy0)
  );

  spi_slave_mem #(.WIDTH(8), .DEPTH(128), .DEV_ID(1)) u_dut1 (
    .i_pclk(pclk), .i_prst(prst), .i_sclk(sclk), .i_mosi(mosi), .i_cs(cs),
    .o_miso(miso1), .o_wr_valid(wrv1), .o_wr_addr(wra1), .o_wr_data(wrd1),
    .o_rd_valid(rdv1), .o_busy(busy1)
  );

  always @(negedge pclk) begin
    if (mon_en) begin
      if (wrv0) wr_cnt0++;
      if (rdv0) rd_cnt0++;
      if (wrv0 && rdv0) both_cnt++;
      if (wrv1) wr_cnt1++;
      if (rdv1) rd_cnt1++;
      if (miso1 !== 1'b1) miso1_low++;
      if (busy1 !== 1'b0) busy1_hi++;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic send_bit(input logic b, output logic seen);
    mosi = b;
    #40;
    seen = miso0;
    sclk = 1'b0;
    #40;
    sclk = 1'b1;
  endtask

  task automatic send_byte(input logic [7:0] v, output logic [7:0] seen);
    logic s;
    for (int i = 0; i < 8; i++) begin
      send_bit(v[i], s);
      seen[i] = s;
    end
  endtask

  task automatic xfer(input logic [7:0] a, input logic [7:0] d, output logic [7:0] rd);
    logic [7:0] junk;
    send_byte(a, junk);
    mosi = 1'b1;
    #80;
    send_byte(d, rd);
    mosi = 1'b1;
    #80;
  endtask

  task automatic frame_start(input logic [3:0] sel);
    cs = sel;
    #60;
  endtask

  task automatic frame_end();
    cs = 4'b0000;
    #60;
  endtask

  initial begin
    logic [7:0] rd, rd2, junk;
    logic       s;
    int         w0, r0;

    // async reset pulse between pclk edges
    #2 prst = 1'b1;
    #1;
    check("rst_miso", miso0, 1'b1);
    check("rst_busy", busy0, 1'b0);
    check("rst_wrv", wrv0, 1'b0);
    check("rst_rdv", rdv0, 1'b0);
    #17 prst = 1'b0;
    #20;
    check("rst_wr_addr", wra0, 7'h00);
    check("rst_wr_data", wrd0, 8'h00);
    mon_en = 1'b1;

    // read after reset returns zero
    r0 = rd_cnt0;
    frame_start(4'b0001);
    check("addr_idle_busy", busy0, 1'b0);
    xfer(8'h05, 8'hFF, rd);
    frame_end();
    check("rd_after_rst", rd, 8'h00);
    check("rd_after_rst_pulse", rd_cnt0 - r0, 1);

    // single write then read-back
    w0 = wr_cnt0;
    frame_start(4'b0001);
    xfer(8'h85, 8'hA5, junk);
    frame_end();
    check("wr85_pulses", wr_cnt0 - w0, 1);
    check("wr85_addr", wra0, 7'h05);
    check("wr85_data", wrd0, 8'hA5);
    frame_start(4'b0001);
    xfer(8'h05, 8'hFF, rd);
    frame_end();
    check("rd05_bits", rd, 8'hA5);
    check("miso_idle", miso0, 1'b1);

    // chained transactions under one cs assertion
    w0 = wr_cnt0;
    r0 = rd_cnt0;
    frame_start(4'b0001);
    xfer(8'h81, 8'h3C, junk);
    xfer(8'h82, 8'hC3, junk);
    check("chain_wr_pulses", wr_cnt0 - w0, 2);
    check("chain_wr_addr", wra0, 7'h02);
    check("chain_wr_data", wrd0, 8'hC3);
    xfer(8'h01, 8'hFF, rd);
    xfer(8'h02, 8'hFF, rd2);
    frame_end();
    check("chain_rd01", rd, 8'h3C);
    check("chain_rd02", rd2, 8'hC3);
    check("chain_rd_pulses", rd_cnt0 - r0, 2);

    // abort after 5 data bits of a write
    w0 = wr_cnt0;
    frame_start(4'b0001);
    send_byte(8'h87, junk);
    #80;
    for (int i = 0; i < 5; i++) send_bit(1'b1, s);
    check("abort_busy_mid", busy0, 1'b1);
    frame_end();
    check("abort_busy", busy0, 1'b0);
    check("abort_miso", miso0, 1'b1);
    check("abort_no_wr", wr_cnt0 - w0, 0);
    frame_start(4'b0001);
    xfer(8'h07, 8'hFF, rd);
    frame_end();
    check("abort_mem7", rd, 8'h00);

    // frame addressed only to cs[0]; DEV_ID=1 instance must stay silent
    frame_start(4'b0001);
    xfer(8'h88, 8'h5A, junk);
    frame_end();
    check("desel_dut0_addr", wra0, 7'h08);
    check("desel_dut0_data", wrd0, 8'h5A);
    check("desel_dut1_wr", wr_cnt1, 0);

    // reset in the middle of a read data phase
    frame_start(4'b0001);
    send_byte(8'h05, junk);
    #80;
    send_bit(1'b1, s);
    check("mid_rd_b0", s, 1'b1);
    send_bit(1'b1, s);
    check("mid_rd_b1", s, 1'b0);
    send_bit(1'b1, s);
    check("mid_rd_b2", s, 1'b1);
    check("mid_rd_b3_pre", miso0, 1'b0);
    #3 prst = 1'b1;
    #1;
    check("midrst_miso", miso0, 1'b1);
    check("midrst_busy", busy0, 1'b0);
    #6;
    cs = 4'b0000;
    #20 prst = 1'b0;
    #40;
    frame_start(4'b0001);
    xfer(8'h05, 8'hFF, rd);
    frame_end();
    check("midrst_mem_clear", rd, 8'h00);
    w0 = wr_cnt0;
    frame_start(4'b0001);
    xfer(8'h90, 8'h11, junk);
    frame_end();
    check("post_rst_wr_pulse", wr_cnt0 - w0, 1);
    check("post_rst_wr_addr", wra0, 7'h10);
    check("post_rst_wr_data", wrd0, 8'h11);
    frame_start(4'b0001);
    xfer(8'h10, 8'hFF, rd);
    frame_end();
    check("post_rst_rd", rd, 8'h11);

    check("never_both_pulses", both_cnt, 0);
    check("dut1_no_wr", wr_cnt1, 0);
    check("dut1_no_rd", rd_cnt1, 0);
    check("dut1_miso_high", miso1_low, 0);
    check("dut1_never_busy", busy1_hi, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
